// File: rtl/elevator_scan_controller_pkg.sv
// Shared state encodings and parameter defaults for the SCAN elevator controller.
package elevator_scan_controller_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MOVE_UP   = 2'd1;
  localparam logic [1:0] ST_MOVE_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR_OPEN = 2'd3;

  localparam int unsigned DEF_N_FLOORS      = 5;
  localparam int unsigned DEF_TRAVEL_CYCLES = 4;
  localparam int unsigned DEF_DOOR_CYCLES   = 6;

endpackage

// File: rtl/elevator_timer.sv
// Width-parametrised up-counter; tc flags the last count before wrap (count == limit-1).
module elevator_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == limit - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scan_controller.sv
// N-floor SCAN elevator controller: request latch, ahead/behind reduction, motion/door FSM.
module elevator_scan_controller
  import elevator_scan_controller_pkg::*;
#(
  parameter  int unsigned N_FLOORS      = DEF_N_FLOORS,
  parameter  int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter  int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES,
  localparam int unsigned FW            = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] hall_btn,
  input  logic [N_FLOORS-1:0] car_btn,
  input  logic                hold,
  output logic [FW-1:0]       cur_floor,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
);

  localparam int unsigned MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = $clog2(MAXC + 1);

  function automatic logic any_above(input logic [N_FLOORS-1:0] v, input logic [FW-1:0] f);
    any_above = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (i > 32'(f) && v[i]) any_above = 1'b1;
    end
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] v, input logic [FW-1:0] f);
    any_below = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (i < 32'(f) && v[i]) any_below = 1'b1;
    end
  endfunction

  logic [1:0]          state, next_state;
  logic [FW-1:0]       floor_next;
  logic                dir_next;
  logic                restart;
  logic                tc;
  logic                timer_clear;
  logic [TW-1:0]       limit;
  logic [N_FLOORS-1:0] clr_mask;
  logic [N_FLOORS-1:0] pending_next;

  always_comb begin
    next_state = state;
    floor_next = cur_floor;
    dir_next   = dir_up;
    restart    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending[cur_floor]) begin
          next_state = ST_DOOR_OPEN;
        end else if (any_above(pending, cur_floor) &&
                     (dir_up || !any_below(pending, cur_floor))) begin
          next_state = ST_MOVE_UP;
          dir_next   = 1'b1;
        end else if (any_below(pending, cur_floor)) begin
          next_state = ST_MOVE_DOWN;
          dir_next   = 1'b0;
        end
      end
      // Arrival decisions look at the floor being entered, not the one being left.
      ST_MOVE_UP: begin
        if (tc) begin
          floor_next = cur_floor + 1'b1;
          if (pending[floor_next])                 next_state = ST_DOOR_OPEN;
          else if (!any_above(pending, floor_next)) next_state = ST_IDLE;
        end
      end
      ST_MOVE_DOWN: begin
        if (tc) begin
          floor_next = cur_floor - 1'b1;
          if (pending[floor_next])                 next_state = ST_DOOR_OPEN;
          else if (!any_below(pending, floor_next)) next_state = ST_IDLE;
        end
      end
      ST_DOOR_OPEN: begin
        restart = hold | hall_btn[cur_floor] | car_btn[cur_floor];
        if (tc && !restart) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (state == ST_DOOR_OPEN || next_state == ST_DOOR_OPEN) clr_mask[floor_next] = 1'b1;
    pending_next = (pending | hall_btn | car_btn) & ~clr_mask;
  end

  assign limit       = (state == ST_DOOR_OPEN) ? TW'(DOOR_CYCLES) : TW'(TRAVEL_CYCLES);
  assign timer_clear = (state == ST_IDLE) || (next_state != state) || restart;

  elevator_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state != ST_IDLE),
    .limit  (limit),
    .tc     (tc)
  );

  // Outputs are decoded from next-state values so every port is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      pending    <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      cur_floor  <= floor_next;
      dir_up     <= dir_next;
      pending    <= pending_next;
      motor_up   <= (next_state == ST_MOVE_UP);
      motor_down <= (next_state == ST_MOVE_DOWN);
      door_open  <= (next_state == ST_DOOR_OPEN);
      busy       <= (next_state != ST_IDLE) || (|pending_next);
    end
  end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for elevator_scan_controller: 5-floor instance plus a 7-floor instance.
module tb_elevator_scan_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] hall_btn = '0;
  logic [4:0] car_btn = '0;
  logic       hold = 1'b0;
  logic [2:0] cur_floor;
  logic       motor_up, motor_down, door_open, dir_up, busy;
  logic [4:0] pending;

  logic [6:0] hall7 = '0;
  logic [6:0] car7 = '0;
  logic [2:0] cur7;
  logic       motor_up7, motor_down7, door7, dir7, busy7;
  logic [6:0] pending7;

  int total = 0;
  int bad = 0;
  logic saw_down;
  logic [2:0] max7;

  always #5 clk = ~clk;

  elevator_scan_controller #(.N_FLOORS(5), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
    .clk(clk), .reset(reset), .hall_btn(hall_btn), .car_btn(car_btn), .hold(hold),
    .cur_floor(cur_floor), .motor_up(motor_up), .motor_down(motor_down),
    .door_open(door_open), .dir_up(dir_up), .pending(pending), .busy(busy)
  );

  elevator_scan_controller #(.N_FLOORS(7), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut7 (
    .clk(clk), .reset(reset), .hall_btn(hall7), .car_btn(car7), .hold(1'b0),
    .cur_floor(cur7), .motor_up(motor_up7), .motor_down(motor_down7),
    .door_open(door7), .dir_up(dir7), .pending(pending7), .busy(busy7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (motor_down) saw_down = 1'b1;
    if (cur7 > max7) max7 = cur7;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    ticks(3);
    reset = 1'b1;
    tick();
    saw_down = 1'b0;
    max7 = '0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    ticks(3);
    total++; if (cur_floor !== 3'd0) begin bad++; $display("FAIL rst_cur got=%0d exp=0", cur_floor); end
    reset = 1'b1;
    tick();
    total++; if ({motor_up, motor_down, door_open} !== 3'b000) begin bad++; $display("FAIL rst_outs got=%b exp=000", {motor_up, motor_down, door_open}); end
    total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL rst_dir got=%b exp=1", dir_up); end
    total++; if (pending !== 5'b0) begin bad++; $display("FAIL rst_pending got=%b exp=00000", pending); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_request();
    apply_reset();
    car_btn = 5'b00100; tick(); car_btn = '0;
    total++; if (pending !== 5'b00100) begin bad++; $display("FAIL t2_pending got=%b exp=00100", pending); end
    total++; if (motor_up !== 1'b0) begin bad++; $display("FAIL t2_motor_early got=%b exp=0", motor_up); end
    tick();
    total++; if (motor_up !== 1'b1) begin bad++; $display("FAIL t2_motor got=%b exp=1", motor_up); end
    ticks(4);
    total++; if (cur_floor !== 3'd1) begin bad++; $display("FAIL t2_cur1 got=%0d exp=1", cur_floor); end
    ticks(4);
    total++; if ({cur_floor, door_open, motor_up} !== {3'd2, 1'b1, 1'b0}) begin bad++; $display("FAIL t2_arrive got=%0d/%b/%b exp=2/1/0", cur_floor, door_open, motor_up); end
    total++; if (pending !== 5'b0) begin bad++; $display("FAIL t2_cleared got=%b exp=00000", pending); end
    ticks(5);
    total++; if (door_open !== 1'b1) begin bad++; $display("FAIL t2_door_15 got=%b exp=1", door_open); end
    tick();
    total++; if (door_open !== 1'b0) begin bad++; $display("FAIL t2_door_16 got=%b exp=0", door_open); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_busy got=%b exp=0", busy); end
  endtask

  task automatic test_pass_through_stops();
    apply_reset();
    car_btn = 5'b10000; tick(); car_btn = '0;
    tick();
    hall_btn = 5'b01010; tick(); hall_btn = '0;
    total++; if (pending !== 5'b11010) begin bad++; $display("FAIL t3_pending got=%b exp=11010", pending); end
    ticks(3);
    total++; if ({cur_floor, door_open} !== {3'd1, 1'b1}) begin bad++; $display("FAIL t3_stop1 got=%0d/%b exp=1/1", cur_floor, door_open); end
    ticks(6);
    total++; if (door_open !== 1'b0) begin bad++; $display("FAIL t3_close1 got=%b exp=0", door_open); end
    tick();
    total++; if (motor_up !== 1'b1) begin bad++; $display("FAIL t3_resume got=%b exp=1", motor_up); end
    ticks(8);
    total++; if ({cur_floor, door_open, pending} !== {3'd3, 1'b1, 5'b10000}) begin bad++; $display("FAIL t3_stop3 got=%0d/%b/%b exp=3/1/10000", cur_floor, door_open, pending); end
    ticks(11);
    total++; if ({cur_floor, door_open, dir_up, pending} !== {3'd4, 1'b1, 1'b1, 5'b0}) begin bad++; $display("FAIL t3_top got=%0d/%b/%b/%b exp=4/1/1/00000", cur_floor, door_open, dir_up, pending); end
    total++; if (saw_down !== 1'b0) begin bad++; $display("FAIL t3_no_reverse got=%b exp=0", saw_down); end
  endtask

  task automatic test_reversal();
    apply_reset();
    car_btn = 5'b00100; tick(); car_btn = '0;
    ticks(9);
    car_btn = 5'b10000; hall_btn = 5'b00001; tick(); car_btn = '0; hall_btn = '0;
    total++; if (pending !== 5'b10001) begin bad++; $display("FAIL t4_pending got=%b exp=10001", pending); end
    ticks(5);
    total++; if ({door_open, dir_up, motor_down} !== 3'b010) begin bad++; $display("FAIL t4_close2 got=%b exp=010", {door_open, dir_up, motor_down}); end
    tick();
    total++; if (motor_up !== 1'b1) begin bad++; $display("FAIL t4_up_first got=%b exp=1", motor_up); end
    ticks(8);
    total++; if ({cur_floor, door_open, pending} !== {3'd4, 1'b1, 5'b00001}) begin bad++; $display("FAIL t4_at4 got=%0d/%b/%b exp=4/1/00001", cur_floor, door_open, pending); end
    ticks(6);
    total++; if ({door_open, motor_up, motor_down} !== 3'b000) begin bad++; $display("FAIL t4_idle4 got=%b exp=000", {door_open, motor_up, motor_down}); end
    tick();
    total++; if ({motor_down, dir_up} !== 2'b10) begin bad++; $display("FAIL t4_down got=%b exp=10", {motor_down, dir_up}); end
    ticks(16);
    total++; if ({cur_floor, door_open, pending} !== {3'd0, 1'b1, 5'b0}) begin bad++; $display("FAIL t4_at0 got=%0d/%b/%b exp=0/1/00000", cur_floor, door_open, pending); end
  endtask

  task automatic test_hold();
    apply_reset();
    car_btn = 5'b00100; tick(); car_btn = '0;
    ticks(14);
    total++; if (door_open !== 1'b1) begin bad++; $display("FAIL t5_open got=%b exp=1", door_open); end
    hold = 1'b1; tick(); hold = 1'b0;
    total++; if (door_open !== 1'b1) begin bad++; $display("FAIL t5_hold got=%b exp=1", door_open); end
    ticks(5);
    car_btn = 5'b00100; tick(); car_btn = '0;
    total++; if ({door_open, pending} !== {1'b1, 5'b0}) begin bad++; $display("FAIL t5_btn_here got=%b/%b exp=1/00000", door_open, pending); end
    ticks(5);
    total++; if (door_open !== 1'b1) begin bad++; $display("FAIL t5_still got=%b exp=1", door_open); end
    tick();
    total++; if (door_open !== 1'b0) begin bad++; $display("FAIL t5_close got=%b exp=0", door_open); end
  endtask

  task automatic test_same_floor();
    apply_reset();
    hall_btn = 5'b00001; tick(); hall_btn = '0;
    total++; if ({pending, door_open, motor_up} !== {5'b00001, 1'b0, 1'b0}) begin bad++; $display("FAIL t6_k1 got=%b/%b/%b exp=00001/0/0", pending, door_open, motor_up); end
    tick();
    total++; if ({door_open, motor_up, motor_down, cur_floor, pending} !== {3'b100, 3'd0, 5'b0}) begin bad++; $display("FAIL t6_k2 got=%b/%b/%b/%0d/%b exp=1/0/0/0/00000", door_open, motor_up, motor_down, cur_floor, pending); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    hall_btn = 5'b01000; car_btn = 5'b01000; tick(); hall_btn = '0; car_btn = '0;
    total++; if ({pending, busy} !== {5'b01000, 1'b1}) begin bad++; $display("FAIL sim_press got=%b/%b exp=01000/1", pending, busy); end
  endtask

  task automatic test_seven_floors();
    apply_reset();
    car7 = 7'b1000000; tick(); car7 = '0;
    ticks(25);
    total++; if ({cur7, door7} !== {3'd6, 1'b1}) begin bad++; $display("FAIL n7_arrive got=%0d/%b exp=6/1", cur7, door7); end
    ticks(10);
    total++; if ({cur7, max7, motor_up7} !== {3'd6, 3'd6, 1'b0}) begin bad++; $display("FAIL n7_top got=%0d/%0d/%b exp=6/6/0", cur7, max7, motor_up7); end
  endtask

  task automatic test_reset_mid_travel();
    apply_reset();
    car_btn = 5'b10000; tick(); car_btn = '0;
    ticks(6);
    total++; if ({cur_floor, motor_up} !== {3'd1, 1'b1}) begin bad++; $display("FAIL mid_moving got=%0d/%b exp=1/1", cur_floor, motor_up); end
    #2 reset = 1'b0;
    #1;
    total++; if ({cur_floor, motor_up, motor_down, door_open, dir_up, busy, pending} !== {3'd0, 5'b00010, 5'b0}) begin bad++; $display("FAIL mid_reset got=%0d/%b/%b/%b/%b/%b/%b exp=0/0/0/0/1/0/00000", cur_floor, motor_up, motor_down, door_open, dir_up, busy, pending); end
    reset = 1'b1;
    tick();
  endtask

  initial begin
    saw_down = 1'b0;
    max7 = '0;
    test_reset();
    test_single_request();
    test_pass_through_stops();
    test_reversal();
    test_hold();
    test_same_floor();
    test_simultaneous();
    test_seven_floors();
    test_reset_mid_travel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
